// File: rtl/matvec_mac_engine_pkg.sv
// Shared constants and types for the matrix-vector MAC engine and the fetch engine feeding it.
// Default stream lengths live here so both ends agree on vector and row counts.
package matvec_mac_engine_pkg;

  localparam int MATVEC_DATA_W   = 8;
  localparam int MATVEC_ACC_W    = 32;
  localparam int MATVEC_VEC_LEN  = 8;
  localparam int MATVEC_NUM_ROWS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    MAC,
    EMIT,
    DONE
  } matvec_state_t;

  // Counter width that stays legal (>= 1 bit) even for a single-element vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matvec_mac_engine_mac_unit.sv
// Combinational signed multiply-accumulate step: acc_out = acc_in + sext(x * w).
// Defining MATVEC_SATURATE_EN clamps each step to the ACC_W range; otherwise the sum wraps.
module matvec_mac_unit
  import matvec_mac_engine_pkg::*;
#(
  parameter int DATA_W = MATVEC_DATA_W,
  parameter int ACC_W  = MATVEC_ACC_W
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [ACC_W-1:0]  acc_out
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
`ifdef MATVEC_SATURATE_EN
  logic signed [ACC_W:0]      sum_wide;
`endif

  always_comb begin
    prod     = (2*DATA_W)'(x) * (2*DATA_W)'(w);
    prod_ext = ACC_W'(prod);
`ifdef MATVEC_SATURATE_EN
    // One guard bit: overflow shows up as the two top bits disagreeing.
    sum_wide = (ACC_W+1)'(acc_in) + (ACC_W+1)'(prod_ext);
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_out = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_out = sum_wide[ACC_W-1:0];
    end
`else
    acc_out = acc_in + prod_ext;
`endif
  end

endmodule

// File: rtl/matvec_mac_engine.sv
// Row-by-row signed matrix-vector MAC fed by valid/ready x and weight streams, one result per row.
// Accumulate behaviour (wrap or clamp) is selected by the MATVEC_SATURATE_EN macro in matvec_mac_unit.
module matvec_mac_engine
  import matvec_mac_engine_pkg::*;
#(
  parameter int DATA_W   = MATVEC_DATA_W,
  parameter int ACC_W    = MATVEC_ACC_W,
  parameter int VEC_LEN  = MATVEC_VEC_LEN,
  parameter int NUM_ROWS = MATVEC_NUM_ROWS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          x_vld,
  output logic                          x_rdy,
  input  logic signed [DATA_W-1:0]      x_data,
  input  logic                          w_vld,
  output logic                          w_rdy,
  input  logic signed [DATA_W-1:0]      w_data,
  output logic                          y_vld,
  input  logic                          y_rdy,
  output logic signed [ACC_W-1:0]       y_data,
  output logic [$clog2(NUM_ROWS):0]     y_row
);

  localparam int XC_W  = cnt_w(VEC_LEN);
  localparam int ROW_W = $clog2(NUM_ROWS) + 1;
  localparam logic [XC_W-1:0]  LAST_EL  = XC_W'(VEC_LEN - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  matvec_state_t state_reg, state_next;

  logic [XC_W-1:0]         el_cnt_reg;
  logic [ROW_W-1:0]        row_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [DATA_W-1:0] x_buf [VEC_LEN];
  logic signed [DATA_W-1:0] x_sel;

  logic x_fire, w_fire, y_fire, last_el, enter_mac;

  assign x_fire    = x_vld && x_rdy;
  assign w_fire    = w_vld && w_rdy;
  assign y_fire    = y_vld && y_rdy;
  assign last_el   = (el_cnt_reg == LAST_EL);
  assign enter_mac = (state_next == MAC) && (state_reg != MAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = LOAD_X;
      LOAD_X:  if (x_fire && last_el) state_next = MAC;
      MAC:     if (w_fire && last_el) state_next = EMIT;
      EMIT:    if (y_fire) state_next = (row_reg == LAST_ROW) ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never combinationally on the valids.
  always_comb begin
    busy  = (state_reg != IDLE);
    x_rdy = (state_reg == LOAD_X);
    w_rdy = (state_reg == MAC);
    y_vld = (state_reg == EMIT);
    done  = (state_reg == DONE);
  end

  assign y_data = acc_reg;
  assign y_row  = row_reg;

  // One element counter serves both the x load index and the weight index within a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      el_cnt_reg <= '0;
      row_reg    <= '0;
      acc_reg    <= '0;
    end else begin
      if (x_fire || w_fire) begin
        el_cnt_reg <= last_el ? '0 : el_cnt_reg + 1'b1;
      end
      if (w_fire) begin
        acc_reg <= acc_sum;
      end else if (enter_mac) begin
        acc_reg <= '0;
      end
      if (y_fire) begin
        row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_xbuf
    logic signed [DATA_W-1:0] x_elem_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_elem_reg <= '0;
      end else if (x_fire && (el_cnt_reg == XC_W'(gi))) begin
        x_elem_reg <= x_data;
      end
    end

    assign x_buf[gi] = x_elem_reg;
  end

  assign x_sel = x_buf[el_cnt_reg];

  matvec_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .x       (x_sel),
    .w       (w_data),
    .acc_in  (acc_reg),
    .acc_out (acc_sum)
  );

endmodule
